// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side drain stage.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // Beat counter width: ceil(log2(pkt_len)), never narrower than one bit.
  function automatic int beat_width(input int pkt_len);
    return (pkt_len <= 2) ? 1 : $clog2(pkt_len);
  endfunction

endpackage

// File: rtl/pkt_beat_cnt.sv
// Modulo-PKT_LEN beat counter; tc flags the final beat of the current packet.
module pkt_beat_cnt
  import fifo_pkg::*;
#(
  parameter int PKT_LEN = 4,
  parameter int W       = beat_width(PKT_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(PKT_LEN - 1);

  logic [W-1:0] beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (inc) begin
      beat <= (beat == LAST) ? '0 : beat + 1'b1;
    end
  end

  assign tc = (beat == LAST);

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a 2-entry skid buffer and presents it as a
// packetised valid/ready stream; downstream ready never reaches the pop path.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int D_SIZE  = 16,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic              r_clk,
  input  logic              i_r_rst,
  input  logic              i_en,
  input  logic              i_fifo_empty,
  input  logic [D_SIZE-1:0] i_fifo_data,
  output logic              o_fifo_inc,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [D_SIZE-1:0] o_m_data,
  output logic              o_m_last,
  output logic [CNT_W-1:0]  o_pop_count
);

  localparam int BEAT_W = beat_width(PKT_LEN);

  occ_t              cnt;
  logic [D_SIZE-1:0] head;
  logic [D_SIZE-1:0] tail;
  logic              pop;
  logic              fire;
  logic              beat_tc;

  // Pop decision uses only registered occupancy, so i_m_ready cannot reach o_fifo_inc.
  // Reset also blocks popping because the FIFO read side is being reset alongside us.
  assign pop        = i_en & ~i_fifo_empty & (cnt != TWO) & ~i_r_rst;
  assign o_fifo_inc = pop;

  assign o_m_valid = (cnt != EMPTY);
  assign o_m_data  = head;
  assign fire      = o_m_valid & i_m_ready;
  assign o_m_last  = o_m_valid & beat_tc;

  always_ff @(posedge r_clk) begin
    if (i_r_rst) begin
      cnt  <= EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({pop, fire})
        2'b10: begin
          if (cnt == EMPTY) begin
            cnt  <= ONE;
            head <= i_fifo_data;
          end else if (cnt == ONE) begin
            cnt  <= TWO;
            tail <= i_fifo_data;
          end
        end
        2'b01: begin
          if (cnt == ONE) begin
            cnt <= EMPTY;
          end else if (cnt == TWO) begin
            cnt  <= ONE;
            head <= tail;
          end
        end
        2'b11: begin
          head <= i_fifo_data;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  always_ff @(posedge r_clk) begin
    if (i_r_rst) begin
      o_pop_count <= '0;
    end else if (pop) begin
      o_pop_count <= o_pop_count + 1'b1;
    end
  end

  pkt_beat_cnt #(
    .PKT_LEN (PKT_LEN),
    .W       (BEAT_W)
  ) u_beat_cnt (
    .clk (r_clk),
    .rst (i_r_rst),
    .inc (fire),
    .tc  (beat_tc)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a show-ahead FIFO model feeds the DUT and
// every stream beat is captured and compared against hand-computed values.
module tb_fifo_rd_stream;

  localparam int D_SIZE  = 16;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 4;

  logic              r_clk;
  logic              i_r_rst;
  logic              i_en;
  logic              i_fifo_empty;
  logic [D_SIZE-1:0] i_fifo_data;
  logic              o_fifo_inc;
  logic              o_m_valid;
  logic              i_m_ready;
  logic [D_SIZE-1:0] o_m_data;
  logic              o_m_last;
  logic [CNT_W-1:0]  o_pop_count;

  logic [D_SIZE-1:0] fifo_mem [0:2047];
  int                rd_ptr;
  int                wr_ptr;
  logic              fifo_flush;

  int                n_compared;
  int                n_mismatched;
  int                n_beats;
  int                n_incs;
  logic [D_SIZE-1:0] beat_data [0:1023];
  logic              beat_last [0:1023];
  int                beat_cyc  [0:1023];

  fifo_rd_stream #(
    .D_SIZE  (D_SIZE),
    .PKT_LEN (PKT_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .r_clk        (r_clk),
    .i_r_rst      (i_r_rst),
    .i_en         (i_en),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_inc   (o_fifo_inc),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_data     (o_m_data),
    .o_m_last     (o_m_last),
    .o_pop_count  (o_pop_count)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // Show-ahead FIFO model: head word visible whenever non-empty, advanced by o_fifo_inc.
  assign i_fifo_empty = (rd_ptr == wr_ptr);
  assign i_fifo_data  = fifo_mem[rd_ptr[10:0]];

  always @(posedge r_clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (o_fifo_inc) rd_ptr <= rd_ptr + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ready);
    @(negedge r_clk);
    i_en      = en;
    i_m_ready = ready;
    #1;
  endtask

  task automatic push(input logic [D_SIZE-1:0] v);
    fifo_mem[wr_ptr[10:0]] = v;
    wr_ptr++;
  endtask

  task automatic clearCapture();
    n_beats = 0;
    n_incs  = 0;
  endtask

  task automatic doReset();
    @(negedge r_clk);
    i_r_rst    = 1'b1;
    fifo_flush = 1'b1;
    i_en       = 1'b0;
    i_m_ready  = 1'b0;
    repeat (2) @(negedge r_clk);
    i_r_rst    = 1'b0;
    fifo_flush = 1'b0;
    clearCapture();
  endtask

  // Runs cycles, recording each beat that will fire on the following edge.
  task automatic runCycles(input int cycles, input logic en, input logic ready,
                           input bit rand_ready, input int stop_beats);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(en, rand_ready ? 1'($urandom_range(0, 1)) : ready);
      if (o_fifo_inc) n_incs++;
      if (o_m_valid && i_m_ready && n_beats < 1024) begin
        beat_data[n_beats] = o_m_data;
        beat_last[n_beats] = o_m_last;
        beat_cyc[n_beats]  = c;
        n_beats++;
      end
      if (stop_beats > 0 && n_beats >= stop_beats) break;
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rd_ptr       = 0;
    wr_ptr       = 0;
    fifo_flush   = 1'b0;
    i_r_rst      = 1'b1;
    i_en         = 1'b1;
    i_m_ready    = 1'b0;
    clearCapture();

    // Reset held with a non-empty FIFO: nothing pops, outputs idle.
    push(16'hAAAA);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("rst_inc",   32'(o_fifo_inc),  0);
      checkOutput("rst_valid", 32'(o_m_valid),   0);
      checkOutput("rst_count", 32'(o_pop_count), 0);
    end
    checkOutput("rst_data", 32'(o_m_data), 0);
    checkOutput("rst_last", 32'(o_m_last), 0);
    @(negedge r_clk);
    i_r_rst = 1'b0;
    #1;
    checkOutput("rel_inc", 32'(o_fifo_inc), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rel_valid", 32'(o_m_valid),   1);
    checkOutput("rel_data",  32'(o_m_data),    32'hAAAA);
    checkOutput("rel_count", 32'(o_pop_count), 1);

    // Streaming eight words with ready high: one beat per cycle, last every 4th.
    doReset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    runCycles(9, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("stream_beats", n_beats, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_data", 32'(beat_data[i]), i + 1);
      checkOutput("stream_last", 32'(beat_last[i]), (i % 4 == 3) ? 1 : 0);
      checkOutput("stream_cyc",  beat_cyc[i], i + 1);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("stream_count", 32'(o_pop_count), 8);
    checkOutput("stream_idle",  32'(o_m_valid),   0);

    // Backpressure: two words buffered, head held, then drained in order without gaps.
    doReset();
    for (int i = 1; i <= 5; i++) push(16'(i));
    runCycles(6, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("bp_pops",  n_incs, 2);
    checkOutput("bp_valid", 32'(o_m_valid),   1);
    checkOutput("bp_data",  32'(o_m_data),    1);
    checkOutput("bp_count", 32'(o_pop_count), 2);
    clearCapture();
    runCycles(8, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("bp_beats", n_beats, 5);
    checkOutput("bp_pops2", n_incs, 3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_order", 32'(beat_data[i]), i + 1);
      checkOutput("bp_cyc",   beat_cyc[i], i);
    end

    // Enable dropped with two words buffered: they drain, nothing more pops.
    doReset();
    for (int i = 1; i <= 6; i++) push(16'(i));
    runCycles(3, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("en_fill", n_incs, 2);
    clearCapture();
    runCycles(4, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("en_beats", n_beats, 2);
    checkOutput("en_data0", 32'(beat_data[0]), 1);
    checkOutput("en_data1", 32'(beat_data[1]), 2);
    checkOutput("en_incs",  n_incs, 0);
    checkOutput("en_valid", 32'(o_m_valid),   0);
    checkOutput("en_inc",   32'(o_fifo_inc),  0);
    checkOutput("en_count", 32'(o_pop_count), 2);

    // Pop counter wraps in four bits: 17 pops leaves 1.
    doReset();
    for (int i = 0; i < 17; i++) push(16'(16'h10 + i));
    runCycles(20, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("wrap_beats", n_beats, 17);
    checkOutput("wrap_lastw", 32'(beat_data[16]), 32'h20);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wrap_count", 32'(o_pop_count), 1);

    // Random ready over 1000 words: strict order, last on every 4th beat.
    doReset();
    for (int i = 0; i < 1000; i++) push(16'(i * 7 + 3));
    runCycles(6000, 1'b1, 1'b0, 1'b1, 1000);
    checkOutput("rand_done", n_beats, 1000);
    for (int i = 0; i < 1000; i++) begin
      checkOutput("rand_data", 32'(beat_data[i]), 32'(16'(i * 7 + 3)));
      checkOutput("rand_last", 32'(beat_last[i]), (i % 4 == 3) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("rand_count", 32'(o_pop_count), 1000 % 16);

    // Reset after two beats of a packet: buffer cleared, framing restarts at beat 0.
    doReset();
    for (int i = 1; i <= 10; i++) push(16'(i));
    runCycles(3, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("mid_pre", n_beats, 2);
    doReset();
    #1;
    checkOutput("mid_valid", 32'(o_m_valid),   0);
    checkOutput("mid_data",  32'(o_m_data),    0);
    checkOutput("mid_count", 32'(o_pop_count), 0);
    for (int i = 0; i < 8; i++) push(16'(16'h100 + i));
    runCycles(6, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("mid_beats", n_beats, 5);
    checkOutput("mid_first", 32'(beat_data[0]), 32'h100);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mid_last", 32'(beat_last[i]), (i == 3) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
